// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, quotient -> LO, remainder -> HI.
// Fixed latency of WIDTH+2 edges from accept to done, independent of operand values.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             flush,
    input  logic             Unsigned,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_div0;
    logic             r_done;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rmd;

    logic             w_neg1;
    logic             w_neg2;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Magnitude of the most-negative operand wraps to 2^(WIDTH-1), which is correct read as unsigned.
    assign w_neg1 = ~Unsigned & op1[WIDTH-1];
    assign w_neg2 = ~Unsigned & op2[WIDTH-1];
    assign w_abs1 = w_neg1 ? -op1 : op1;
    assign w_abs2 = w_neg2 ? -op2 : op2;

    // Partial remainder is WIDTH+1 bits; the trial difference always fits WIDTH bits when it is kept.
    assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_sub      = w_shift[WIDTH-1:0] - r_dvs;
    assign w_rem_next = w_ge ? w_sub : w_shift[WIDTH-1:0];

    // With a zero divisor the remainder ends as |op1|; the normal sign fix restores op1 exactly.
    assign w_q_fix = r_div0 ? '1 : (r_sign_q ? -r_dvd : r_dvd);
    assign w_r_fix = r_sign_r ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_div0   <= 1'b0;
            r_done   <= 1'b0;
            r_quo    <= '0;
            r_rmd    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !flush) begin
                        r_dvd    <= w_abs1;
                        r_dvs    <= w_abs2;
                        r_rem    <= '0;
                        r_sign_q <= w_neg1 ^ w_neg2;
                        r_sign_r <= w_neg1;
                        r_div0   <= (op2 == '0);
                        r_cnt    <= CW'(WIDTH - 1);
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                        if (r_cnt == '0) begin
                            r_state <= FIX;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                FIX: begin
                    r_state <= IDLE;
                    if (!flush) begin
                        r_quo  <= w_q_fix;
                        r_rmd  <= w_r_fix;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign quotient  = r_quo;
    assign remainder = r_rmd;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes reference results, a negedge monitor checks busy,
// held outputs, result values and fixed latency.
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         flush;
    logic         Unsigned;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .flush     (flush),
        .Unsigned  (Unsigned),
        .op1       (op1),
        .op2       (op2),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    bit          m_active = 1'b0;
    int unsigned m_acc = 0;
    logic [W-1:0] m_qh = '0;
    logic [W-1:0] m_rh = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer division, truncating toward zero for the signed case.
    function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit u);
        exp_t   e;
        longint sa;
        longint sd;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else if (u) begin
            e.q = a / b;
            e.r = a % b;
        end else begin
            sa  = longint'($signed(a));
            sd  = longint'($signed(b));
            e.q = W'(sa / sd);
            e.r = W'(sa % sd);
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", W'(busy), W'(m_active && cyc >= m_acc && cyc <= m_acc + W));
            if (done) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL done_unexpected: got done=1 expected done=0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("quotient", quotient, mon_e.q);
                    check("remainder", remainder, mon_e.r);
                    check("latency", W'(cyc), W'(m_acc + W + 1));
                    m_active = 1'b0;
                    m_qh = mon_e.q;
                    m_rh = mon_e.r;
                end
            end else begin
                check("q_hold", quotient, m_qh);
                check("r_hold", remainder, m_rh);
                if (m_active && cyc > m_acc + W + 1) begin
                    tests++;
                    fails++;
                    $display("FAIL done_timeout: got no done expected done at cycle %0d", m_acc + W + 1);
                    void'(sb.pop_front());
                    m_active = 1'b0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit u, input bit fl);
        op1      = a;
        op2      = b;
        Unsigned = u;
        start    = 1'b1;
        flush    = fl;
        tick();
        start    = 1'b0;
        flush    = 1'b0;
        op1      = $urandom;
        op2      = $urandom;
        Unsigned = 1'($urandom_range(0, 1));
        if (fl) begin
            if (m_active) begin
                void'(sb.pop_back());
                m_active = 1'b0;
            end
        end else if (!m_active) begin
            sb.push_back(ref_div(a, b, u));
            m_active = 1'b1;
            m_acc    = cyc;
        end
    endtask

    task automatic flush_only;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (m_active) begin
            void'(sb.pop_back());
            m_active = 1'b0;
        end
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        tick();
        sb.delete();
        m_active = 1'b0;
        m_qh     = '0;
        m_rh     = '0;
        reset_n  = 1'b1;
    endtask

    task automatic wait_idle;
        for (int i = 0; i < W + 8 && m_active; i++) tick();
    endtask

    task automatic wait_done_cycle;
        for (int i = 0; i < 2 * W && m_active && cyc != m_acc + W + 1; i++) tick();
    endtask

    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           ru;

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        Unsigned = 1'b0;
        op1      = '0;
        op2      = '0;
        tick();
        mon_en = 1'b1;
        do_reset();
        tick();

        issue(32'd100, 32'd7, 1'b1, 1'b0);                wait_idle();
        issue(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);          wait_idle();
        issue(32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);          wait_idle();
        issue(32'h1234_5678, 32'd0, 1'b1, 1'b0);          wait_idle();
        issue(32'h1234_5678, 32'd0, 1'b0, 1'b0);          wait_idle();
        issue(32'h8765_4321, 32'd0, 1'b0, 1'b0);          wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);  wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);  wait_idle();
        issue(32'h8000_0000, 32'd1, 1'b0, 1'b0);          wait_idle();

        issue(32'd10, 32'd3, 1'b0, 1'b0);
        repeat (4) tick();
        issue(32'd50, 32'd5, 1'b0, 1'b0);
        wait_done_cycle();
        issue(32'd50, 32'd5, 1'b0, 1'b0);
        wait_idle();

        issue(32'd1000, 32'd3, 1'b1, 1'b0);
        repeat (8) tick();
        flush_only();
        repeat (3) tick();
        issue(32'd20, 32'd4, 1'b1, 1'b1);
        repeat (3) tick();
        issue(32'd77, 32'd5, 1'b1, 1'b0);
        for (int i = 0; i < 2 * W && cyc != m_acc + W; i++) tick();
        flush_only();
        repeat (3) tick();

        issue(32'd99, 32'd9, 1'b1, 1'b0);
        repeat (5) tick();
        do_reset();
        repeat (2) tick();
        issue(32'd9, 32'd3, 1'b1, 1'b0);                  wait_idle();

        for (int n = 0; n < 60; n++) begin
            ra = $urandom;
            rb = $urandom;
            ru = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = '1; end
                2: rb = W'($urandom_range(1, 15));
                3: rb = {{(W-8){rb[7]}}, rb[7:0]};
                default: ;
            endcase
            issue(ra, rb, ru, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, W + 1)) tick();
                issue($urandom, W'($urandom_range(0, 200)), 1'($urandom_range(0, 1)), 1'b0);
            end
            wait_idle();
        end

        repeat (5) tick();
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
